i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h42, the 7-bit I2C device address answered.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port scl_in  input  1  I2C SCL pin sample, asynchronous to clk.
REQ-005 SHALL have port sda_in  input  1  I2C SDA pin sample, asynchronous to clk.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
REQ-007 SHALL have port regs  output  32  writable bytes R0..R3; R0 is regs[7:0], R3 is regs[31:24].
REQ-008 SHALL have port status  input  32  read-only bytes R4..R7, same byte order as regs.
REQ-009 SHALL have port wr_strobe  output  1  one-cycle pulse when R0..R3 is written over I2C.
REQ-010 SHALL have port wr_idx  output  2  index of the byte written; valid while wr_strobe is 1.
REQ-011 SHALL have port busy  output  1  1 from an address match until STOP or return to IDLE.

Function
REQ-012 SHALL pass scl_in and sda_in through 2-flop synchronizers, then through one edge-detect register.
- Bus events are acted on 3 clk after the pin change.
- clk SHALL be at least 8x the SCL frequency.
REQ-013 SHALL detect START as synchronized SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-014 SHALL sample SDA on SCL rising edges and SHALL change sda_oe only on the cycle after an SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
REQ-016 START in any state SHALL clear the bit counter and go to ADDR; this covers repeated START.
REQ-017 STOP in any state SHALL go to IDLE, release sda_oe and clear busy.
REQ-018 ADDR SHALL shift in 8 bits, MSB first.
- Bits[7:1]==DEV_ADDR: go to ADDR_ACK and drive ACK (sda_oe=1) for the 9th SCL.
- Otherwise: go to IDLE with sda_oe=0.
REQ-019 After ADDR_ACK, R/W bit = 0 SHALL go to PTR; R/W bit = 1 SHALL go to READ, loading the byte at the pointer.
REQ-020 PTR SHALL store byte[2:0] as the 3-bit pointer, ACK it, then go to WRITE.
REQ-021 Each byte received in WRITE SHALL be ACKed.
- Pointer 0..3: the byte is stored into that register, with wr_strobe=1 and wr_idx=pointer for exactly one clk.
- Pointer 4..7: the byte is ignored and wr_strobe stays 0.
REQ-022 READ SHALL shift the selected byte out MSB first.
- A 0 bit sets sda_oe=1; a 1 bit sets sda_oe=0.
- status bytes SHALL be captured when the byte load occurs.
REQ-023 READ_ACK SHALL release SDA and sample the controller's ACK.
- ACK (0): load the next byte and continue.
- NACK (1): go to IDLE.
REQ-024 A write to a register and a local read of regs SHALL never see a partially updated byte; each byte updates in a single clk.

Reset
REQ-025 resetn=0 SHALL asynchronously set the following:
- state IDLE
- sda_oe=0, busy=0, wr_strobe=0, wr_idx=0
- regs=32'h0, pointer=0, bit counter=0
- synchronizer flops to 1 (idle bus level)
REQ-026 Reset mid-transfer SHALL release SDA immediately. After reset is released, the block SHALL ignore the bus until the next START.

Configuration
REQ-027 Macro I2C_TARGET_AUTOINC_EN defined: the pointer SHALL increment modulo 8 (7->0) after each data byte written in WRITE or ACKed in READ.
REQ-028 Macro I2C_TARGET_AUTOINC_EN undefined: the pointer SHALL stay fixed, so repeated bytes target the same register.

Verification
REQ-029 Write 0x84,0x01,0xAA,0x55 (address 0x42 write, pointer 1, two data bytes), then STOP:
- With AUTOINC: R1=0xAA, R2=0x55, two strobes with wr_idx=1 then 2.
- Without AUTOINC: R1=0x55.
- Every byte is ACKed.
REQ-030 Set status=32'hDEADBEEF. Write 0x84,0x04, repeated START, 0x85, read two bytes with ACK then NACK:
- With AUTOINC: returns 0xEF, 0xBE.
- busy=0 after STOP.
REQ-031 Send address byte 0x86 (wrong address): sda_oe stays 0 throughout, no wr_strobe, busy=0.
REQ-032 Write to pointer 6 with data 0x12: the byte is ACKed, wr_strobe never asserts, regs unchanged.
REQ-033 Assert resetn=0 during the 4th data bit of a READ: sda_oe=0 within the same cycle, regs=0; the next full transaction behaves normally.
REQ-034 Read with pointer 7 and AUTOINC: after ACK the second byte returned is R0 (wrap to 0).

Source files
------------

// File: rtl/i2c_target.sv
// I2C target exposing writable bytes R0..R3 (regs) and read-only bytes R4..R7 (status).
// Define I2C_TARGET_AUTOINC_EN to advance the register pointer after every data byte.
module i2c_target #(
   parameter logic [6:0] DEV_ADDR = 7'h42
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [31:0] regs,
   input  logic [31:0] status,
   output logic        wr_strobe,
   output logic [1:0]  wr_idx,
   output logic        busy
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] ADDR      = 4'd1;
   localparam logic [3:0] ADDR_ACK  = 4'd2;
   localparam logic [3:0] PTR       = 4'd3;
   localparam logic [3:0] PTR_ACK   = 4'd4;
   localparam logic [3:0] WRITE     = 4'd5;
   localparam logic [3:0] WRITE_ACK = 4'd6;
   localparam logic [3:0] READ      = 4'd7;
   localparam logic [3:0] READ_ACK  = 4'd8;

`ifdef I2C_TARGET_AUTOINC_EN
   localparam logic [2:0] PTR_STEP = 3'd1;
`else
   localparam logic [2:0] PTR_STEP = 3'd0;
`endif

   logic scl_s1_reg, scl_s2_reg, scl_d_reg;
   logic sda_s1_reg, sda_s2_reg, sda_d_reg;

   // Synchronizers idle high so reset release never fakes a bus edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scl_s1_reg <= 1'b1;
         scl_s2_reg <= 1'b1;
         scl_d_reg  <= 1'b1;
         sda_s1_reg <= 1'b1;
         sda_s2_reg <= 1'b1;
         sda_d_reg  <= 1'b1;
      end else begin
         scl_s1_reg <= scl_in;
         scl_s2_reg <= scl_s1_reg;
         scl_d_reg  <= scl_s2_reg;
         sda_s1_reg <= sda_in;
         sda_s2_reg <= sda_s1_reg;
         sda_d_reg  <= sda_s2_reg;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_s2_reg & ~scl_d_reg;
   assign scl_fall  = ~scl_s2_reg & scl_d_reg;
   assign start_det = scl_s2_reg & scl_d_reg & sda_d_reg & ~sda_s2_reg;
   assign stop_det  = scl_s2_reg & scl_d_reg & ~sda_d_reg & sda_s2_reg;

   logic [3:0] state_reg;
   logic [3:0] bit_cnt_reg;
   logic [7:0] rx_reg;
   logic [7:0] tx_reg;
   logic [2:0] ptr_reg;
   logic       rw_reg;
   logic       sda_oe_reg;
   logic       busy_reg;
   logic       wr_strobe_reg;
   logic [1:0] wr_idx_reg;

   logic [7:0] rx_next;
   logic [2:0] ptr_inc;
   logic       wr_en;
   logic [7:0] byte_sel [0:7];
   logic [7:0] cur_byte;
   logic [7:0] nxt_byte;

   assign rx_next  = {rx_reg[6:0], sda_s2_reg};
   assign ptr_inc  = ptr_reg + PTR_STEP;
   assign wr_en    = (state_reg == WRITE) && scl_rise && (bit_cnt_reg == 4'd7) && !ptr_reg[2];
   assign cur_byte = byte_sel[ptr_reg];
   assign nxt_byte = byte_sel[ptr_inc];

   // Each register byte loads whole in one clk, so local readers never see a torn byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         logic [7:0] byte_reg;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)
               byte_reg <= 8'h00;
            else if (wr_en && (ptr_reg[1:0] == 2'(gi)))
               byte_reg <= rx_next;
         end
         assign regs[gi*8 +: 8]  = byte_reg;
         assign byte_sel[gi]     = byte_reg;
         assign byte_sel[gi + 4] = status[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= 4'd0;
         rx_reg        <= 8'h00;
         tx_reg        <= 8'h00;
         ptr_reg       <= 3'd0;
         rw_reg        <= 1'b0;
         sda_oe_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         wr_strobe_reg <= 1'b0;
         wr_idx_reg    <= 2'd0;
      end else begin
         wr_strobe_reg <= 1'b0;
         if (stop_det) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            sda_oe_reg  <= 1'b0;
            busy_reg    <= 1'b0;
         end else if (start_det) begin
            state_reg   <= ADDR;
            bit_cnt_reg <= 4'd0;
            sda_oe_reg  <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: ;
               ADDR: begin
                  if (scl_rise) begin
                     rx_reg      <= rx_next;
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (bit_cnt_reg == 4'd7) begin
                        if (rx_next[7:1] == DEV_ADDR) begin
                           state_reg <= ADDR_ACK;
                           busy_reg  <= 1'b1;
                           rw_reg    <= rx_next[0];
                        end else begin
                           state_reg <= IDLE;
                           busy_reg  <= 1'b0;
                        end
                     end
                  end
               end
               PTR: begin
                  if (scl_rise) begin
                     rx_reg      <= rx_next;
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (bit_cnt_reg == 4'd7) begin
                        ptr_reg   <= rx_next[2:0];
                        state_reg <= PTR_ACK;
                     end
                  end
               end
               WRITE: begin
                  if (scl_rise) begin
                     rx_reg      <= rx_next;
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (bit_cnt_reg == 4'd7) begin
                        if (!ptr_reg[2]) begin
                           wr_strobe_reg <= 1'b1;
                           wr_idx_reg    <= ptr_reg[1:0];
                        end
                        ptr_reg   <= ptr_inc;
                        state_reg <= WRITE_ACK;
                     end
                  end
               end
               // bit_cnt 8: ACK not yet driven; 9: ninth SCL high seen, release on its fall.
               ADDR_ACK, PTR_ACK, WRITE_ACK: begin
                  if (scl_rise) begin
                     bit_cnt_reg <= 4'd9;
                  end else if (scl_fall && (bit_cnt_reg == 4'd8)) begin
                     sda_oe_reg <= 1'b1;
                  end else if (scl_fall && (bit_cnt_reg == 4'd9)) begin
                     bit_cnt_reg <= 4'd0;
                     if ((state_reg == ADDR_ACK) && rw_reg) begin
                        state_reg  <= READ;
                        tx_reg     <= cur_byte;
                        sda_oe_reg <= ~cur_byte[7];
                     end else begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= (state_reg == ADDR_ACK) ? PTR : WRITE;
                     end
                  end
               end
               READ: begin
                  if (scl_rise) begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_reg == 4'd8) begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= READ_ACK;
                     end else if (bit_cnt_reg != 4'd0) begin
                        tx_reg     <= {tx_reg[6:0], 1'b0};
                        sda_oe_reg <= ~tx_reg[6];
                     end
                  end
               end
               READ_ACK: begin
                  if (scl_rise) begin
                     if (sda_s2_reg) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        bit_cnt_reg <= 4'd0;
                     end else begin
                        bit_cnt_reg <= 4'd9;
                     end
                  end else if (scl_fall && (bit_cnt_reg == 4'd9)) begin
                     ptr_reg     <= ptr_inc;
                     tx_reg      <= nxt_byte;
                     sda_oe_reg  <= ~nxt_byte[7];
                     state_reg   <= READ;
                     bit_cnt_reg <= 4'd0;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign sda_oe    = sda_oe_reg;
   assign busy      = busy_reg;
   assign wr_strobe = wr_strobe_reg;
   assign wr_idx    = wr_idx_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-level controller tasks, a reference register
// model and a scoreboard of expected ACKs, read bytes and write strobes.
module tb_i2c_target;

   localparam int Q = 100;
`ifdef I2C_TARGET_AUTOINC_EN
   localparam logic [2:0] STEP = 3'd1;
`else
   localparam logic [2:0] STEP = 3'd0;
`endif

   logic        clk;
   logic        resetn;
   logic        scl;
   logic        sda_ctl;
   logic        sda_line;
   logic        sda_oe;
   logic [31:0] regs;
   logic [31:0] status;
   logic        wr_strobe;
   logic [1:0]  wr_idx;
   logic        busy;

   assign sda_line = sda_ctl & ~sda_oe;

   i2c_target #(.DEV_ADDR(7'h42)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .scl_in    (scl),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .regs      (regs),
      .status    (status),
      .wr_strobe (wr_strobe),
      .wr_idx    (wr_idx),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t       exp_q[$];
   logic [9:0] exp_strobe_q[$];
   logic [7:0] m_regs [4];

   // Monitor: the only writer of these counters and the strobe log.
   int         oe_cnt     = 0;
   int         busy_cnt   = 0;
   int         strobe_cnt = 0;
   int         strobe_rd  = 0;
   logic [9:0] strobe_log [256];

   always @(negedge clk) begin
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (wr_strobe) begin
         strobe_log[strobe_cnt[7:0]] <= {wr_idx, regs[wr_idx*8 +: 8]};
         strobe_cnt <= strobe_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic check_next(input logic [31:0] obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $error("FAIL scoreboard_empty: observed %h expected <queued value>", obs);
      end else begin
         e = exp_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic check_strobes(input string tag);
      logic [9:0] e;
      check({tag, "_strobe_cnt"}, 32'(strobe_cnt - strobe_rd), 32'(exp_strobe_q.size()));
      while (exp_strobe_q.size() > 0) begin
         e = exp_strobe_q.pop_front();
         if (strobe_rd < strobe_cnt) begin
            check({tag, "_strobe"}, 32'(strobe_log[strobe_rd[7:0]]), 32'(e));
            strobe_rd++;
         end
      end
      strobe_rd = strobe_cnt;
   endtask

   function automatic logic [7:0] model_byte(input logic [2:0] p);
      int idx;
      idx = int'(p[1:0]);
      if (p[2]) return status[idx*8 +: 8];
      return m_regs[idx];
   endfunction

   function automatic logic [31:0] model_regs();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   task automatic bus_start();
      sda_ctl = 1'b1; #Q;
      scl = 1'b1;     #Q;
      sda_ctl = 1'b0; #Q;
      scl = 1'b0;     #Q;
   endtask

   task automatic bus_stop();
      sda_ctl = 1'b0; #Q;
      scl = 1'b1;     #Q;
      sda_ctl = 1'b1; #Q;
      #Q;
   endtask

   task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
      logic ack;
      expect_val(tag, 32'(exp_ack));
      for (int i = 7; i >= 0; i--) begin
         sda_ctl = b[i]; #Q;
         scl = 1'b1;     #(2*Q);
         scl = 1'b0;     #Q;
      end
      sda_ctl = 1'b1; #Q;
      scl = 1'b1;     #Q;
      ack = ~sda_line; #Q;
      scl = 1'b0;     #Q;
      check_next(32'(ack));
   endtask

   task automatic read_byte(input logic nack, input logic [7:0] exp, input string tag);
      logic [7:0] d;
      d = 8'h00;
      expect_val(tag, 32'(exp));
      sda_ctl = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #Q;
         scl = 1'b1; #Q;
         d = {d[6:0], sda_line}; #Q;
         scl = 1'b0; #Q;
      end
      sda_ctl = nack; #Q;
      scl = 1'b1;     #(2*Q);
      scl = 1'b0;     #Q;
      check_next(32'(d));
   endtask

   task automatic wr_txn(input logic [2:0] p, input logic [7:0] d0, input logic [7:0] d1,
                         input int n, input string tag);
      logic [2:0] mp;
      logic [7:0] d;
      mp = p;
      bus_start();
      write_byte(8'h84, 1'b1, {tag, "_addr_ack"});
      check({tag, "_busy"}, 32'(busy), 32'd1);
      write_byte({5'b0, p}, 1'b1, {tag, "_ptr_ack"});
      for (int i = 0; i < n; i++) begin
         d = (i == 0) ? d0 : d1;
         if (!mp[2]) begin
            m_regs[mp[1:0]] = d;
            exp_strobe_q.push_back({mp[1:0], d});
         end
         mp = mp + STEP;
         write_byte(d, 1'b1, {tag, "_data_ack"});
      end
      bus_stop();
      check({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
      check({tag, "_regs"}, regs, model_regs());
      check_strobes(tag);
   endtask

   task automatic rd2_txn(input logic [2:0] p, input string tag);
      logic [2:0] mp;
      mp = p;
      bus_start();
      write_byte(8'h84, 1'b1, {tag, "_addr_ack"});
      write_byte({5'b0, p}, 1'b1, {tag, "_ptr_ack"});
      bus_start();
      write_byte(8'h85, 1'b1, {tag, "_raddr_ack"});
      read_byte(1'b0, model_byte(mp), {tag, "_byte0"});
      mp = mp + STEP;
      read_byte(1'b1, model_byte(mp), {tag, "_byte1"});
      bus_stop();
      check({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
      check_strobes(tag);
   endtask

   int oe_snap;
   int busy_snap;

   initial begin
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      scl     = 1'b1;
      sda_ctl = 1'b1;
      status  = 32'h0;
      resetn  = 1'b0;
      #50;
      check("reset_sda_oe", 32'(sda_oe), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
      check("reset_wr_idx", 32'(wr_idx), 32'd0);
      check("reset_regs", regs, 32'h0);
      #50;
      resetn = 1'b1;
      #(2*Q);

      // Two data bytes at pointer 1.
      wr_txn(3'd1, 8'hAA, 8'h55, 2, "wr_p1");

      // Status read through a repeated START.
      status = 32'hDEADBEEF;
      rd2_txn(3'd4, "rd_p4");

      // Foreign address must be ignored entirely.
      oe_snap   = oe_cnt;
      busy_snap = busy_cnt;
      bus_start();
      write_byte(8'h86, 1'b0, "bad_addr_nack");
      check("bad_addr_busy", 32'(busy), 32'd0);
      bus_stop();
      check("bad_addr_oe_cycles", 32'(oe_cnt - oe_snap), 32'd0);
      check("bad_addr_busy_cycles", 32'(busy_cnt - busy_snap), 32'd0);
      check_strobes("bad_addr");

      // Read-only pointer: ACKed but no strobe, regs untouched.
      wr_txn(3'd6, 8'h12, 8'h00, 1, "wr_p6");

      // Byte lane placement of R0 and R3.
      wr_txn(3'd0, 8'h11, 8'h00, 1, "wr_p0");
      wr_txn(3'd3, 8'h33, 8'h00, 1, "wr_p3");

      // Pointer 7 read; wraps to R0 when auto-increment is on.
      rd2_txn(3'd7, "rd_p7");

      // Reset while the target is driving a 0 data bit.
      status = 32'h0;
      bus_start();
      write_byte(8'h84, 1'b1, "rst_addr_ack");
      write_byte(8'h04, 1'b1, "rst_ptr_ack");
      bus_start();
      write_byte(8'h85, 1'b1, "rst_raddr_ack");
      sda_ctl = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      end
      #Q; scl = 1'b1; #Q;
      check("rst_oe_before", 32'(sda_oe), 32'd1);
      resetn = 1'b0;
      #1;
      check("rst_oe_released", 32'(sda_oe), 32'd0);
      check("rst_regs", regs, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      strobe_rd = strobe_cnt;
      #(Q-1);
      resetn = 1'b1;
      #(2*Q);

      // Without a START the target stays silent.
      write_byte(8'h84, 1'b0, "nostart_nack");
      check("nostart_busy", 32'(busy), 32'd0);

      wr_txn(3'd2, 8'h77, 8'h00, 1, "post_rst_wr");

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
